// File: rtl/btn_toggle_pulse.sv
// btn_toggle_pulse: synchronizes and debounces a raw push-button and issues a
// single-cycle T pulse for every accepted press, suitable for driving the T
// input of a downstream toggle flip-flop.
//
// Optional feature macro: AUTOREPEAT_EN
//   When defined, holding the button produces additional T pulses: the first
//   one REPEAT_DELAY cycles after the press pulse, then one every REPEAT_PERIOD
//   cycles. When undefined, no repeat logic exists and the REPEAT_* parameters
//   are only range-checked.
module btn_toggle_pulse #(
  parameter int unsigned DB_CYCLES     = 32'd1000000,
  parameter int unsigned REPEAT_DELAY  = 32'd50000000,
  parameter int unsigned REPEAT_PERIOD = 32'd10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic T,
  output logic btn_level,
  output logic busy
);

  // Debounce counter: one extra bit keeps DB_CYCLES-1 representable for any
  // legal DB_CYCLES, including 1.
  localparam int unsigned CW = $clog2(DB_CYCLES) + 32'd1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  // Elaboration-time parameter range checks.
  if (DB_CYCLES < 32'd1) begin : gen_db_range_chk
    $error("btn_toggle_pulse: DB_CYCLES must be >= 1");
  end
  if ((REPEAT_DELAY < 32'd1) || (REPEAT_PERIOD < 32'd1)) begin : gen_rpt_range_chk
    $error("btn_toggle_pulse: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_e;

  logic [1:0]    sync_q;
  logic          s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          t_q, t_d;
  logic          level_q, level_d;
  logic          busy_q, busy_d;

`ifdef AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW = $clog2(RPT_MAX) + 32'd1;
  localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 32'd1);
  localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 32'd1);
  localparam logic [RW-1:0] RPT_ONE         = RW'(32'd1);

  // rpt_armed_q: the first (long) repeat delay has elapsed in this HELD stint.
  logic [RW-1:0] rpt_q, rpt_d;
  logic          rpt_armed_q, rpt_armed_d;
`endif

  assign s = sync_q[1];

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_in};
    end
  end

  // Debounce FSM next-state, counter and pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = 1'b0;
`ifdef AUTOREPEAT_EN
    rpt_d       = '0;
    rpt_armed_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s) begin
          state_d = DB_PRESS;
        end else begin
          state_d = IDLE;
        end
      end
      DB_PRESS: begin
        if (!s) begin
          // Bounce: the sampled level wins over a coincident terminal count.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          t_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (!s) begin
          state_d = DB_RELEASE;
        end else begin
          state_d = HELD;
`ifdef AUTOREPEAT_EN
          if (!rpt_armed_q) begin
            if (rpt_q == RPT_DELAY_LAST) begin
              t_d         = 1'b1;
              rpt_d       = '0;
              rpt_armed_d = 1'b1;
            end else begin
              rpt_d       = rpt_q + RPT_ONE;
              rpt_armed_d = 1'b0;
            end
          end else begin
            rpt_armed_d = 1'b1;
            if (rpt_q == RPT_PERIOD_LAST) begin
              t_d   = 1'b1;
              rpt_d = '0;
            end else begin
              rpt_d = rpt_q + RPT_ONE;
            end
          end
`endif
        end
      end
      DB_RELEASE: begin
        if (s) begin
          // Release was a bounce: back to HELD silently.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so the outputs can be registered.
  always_comb begin
    level_d = 1'b0;
    busy_d  = 1'b0;
    case (state_d)
      IDLE: begin
        level_d = 1'b0;
        busy_d  = 1'b0;
      end
      DB_PRESS: begin
        level_d = 1'b0;
        busy_d  = 1'b1;
      end
      HELD, DB_RELEASE: begin
        level_d = 1'b1;
        busy_d  = 1'b1;
      end
      default: begin
        level_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      t_q     <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

`ifdef AUTOREPEAT_EN
  // Auto-repeat counter; cleared whenever the FSM is outside HELD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`endif

  assign T         = t_q;
  assign btn_level = level_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_btn_toggle_pulse.sv
// Self-checking bench for btn_toggle_pulse (DB_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=3). The reference model works on run lengths of the
// synchronized level rather than on FSM states.
module tb_btn_toggle_pulse;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic T;
  logic btn_level;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic m_s1, m_s2;   // btn_in as seen one and two edges ago
  logic m_lvl;        // debounced level
  logic m_t;          // expected T after this edge
  int   m_run;        // consecutive samples disagreeing with m_lvl
  int   m_held;       // edges spent in the current uninterrupted held stint

  // Scenario bookkeeping
  int          edge_n;
  int          first_t;
  int          t_count;
  logic [63:0] t_mask;
  logic        t_prev;

  always #5 clk = ~clk;

  btn_toggle_pulse #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .T        (T),
    .btn_level(btn_level),
    .busy     (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_t = 1'b0;
    m_run = 0; m_held = 0;
  endtask

  task automatic model_edge(input logic b);
    logic s;
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    m_t  = 1'b0;
    if (s != m_lvl) begin
      m_run++;
      if (m_run == DB + 1) begin
        m_lvl  = s;
        m_run  = 0;
        m_held = 0;
        m_t    = s;
      end
    end else begin
      if (m_lvl && m_run == 0) begin
        m_held++;
`ifdef AUTOREPEAT_EN
        if (m_held == RD || (m_held > RD && ((m_held - RD) % RP) == 0)) m_t = 1'b1;
`endif
      end else begin
        m_held = 0;
      end
      m_run = 0;
    end
  endtask

  task automatic mark();
    edge_n = 0; first_t = -1; t_count = 0; t_mask = 64'd0;
  endtask

  task automatic step(input logic b, input logic r);
    @(negedge clk);
    btn_in = b;
    rst    = r;
    if (r) begin
      #1;
      check_val("rst_T", {63'd0, T}, 64'd0);
      check_val("rst_level", {63'd0, btn_level}, 64'd0);
      check_val("rst_busy", {63'd0, busy}, 64'd0);
    end
    @(posedge clk);
    if (r) model_clear();
    else model_edge(b);
    #1;
    check_val("T", {63'd0, T}, {63'd0, m_t});
    check_val("btn_level", {63'd0, btn_level}, {63'd0, m_lvl});
    check_val("busy", {63'd0, busy}, {63'd0, (m_lvl || m_run != 0)});
`ifndef AUTOREPEAT_EN
    check_val("T_consecutive", {63'd0, (t_prev & T)}, 64'd0);
`endif
    t_prev = T;
    edge_n++;
    if (T === 1'b1) begin
      t_count++;
      if (first_t < 0) first_t = edge_n;
      if (edge_n < 64) t_mask = t_mask | (64'd1 << edge_n);
    end
  endtask

  task automatic idle_out(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    logic        lvl;
    logic [63:0] exp_mask;
    rst = 1'b1; btn_in = 1'b0; t_prev = 1'b0;
    model_clear();
    mark();

    // Reset held with the button pressed, then a long press
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    mark();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    check_val("lat_after_reset", first_t, 7);
`ifndef AUTOREPEAT_EN
    check_val("one_pulse_press", t_count, 1);
`endif
    idle_out(12);

    // Short bounce: no pulse, never leaves the unpressed level
    mark();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    idle_out(10);
    check_val("bounce_no_T", t_count, 0);

    // Release glitch while held: still a single pulse
    mark();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    check_val("glitch_one_T", t_count, 1);
    idle_out(12);

    // Reset during DB_PRESS with the button kept high
    mark();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check_val("no_T_before_rst", t_count, 0);
    mark();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    check_val("lat_after_abort", first_t, 7);
    idle_out(12);

    // 30-edge hold: pulse edge set
    mark();
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
`ifdef AUTOREPEAT_EN
    exp_mask = (64'd1 << 7) | (64'd1 << 15) | (64'd1 << 18) | (64'd1 << 21) |
               (64'd1 << 24) | (64'd1 << 27) | (64'd1 << 30);
`else
    exp_mask = 64'd1 << 7;
`endif
    check_val("hold30_pulses", t_mask, exp_mask);
    idle_out(12);

    // Randomized bouncing runs with occasional resets
    lvl = 1'b0;
    for (int k = 0; k < 300; k++) begin
      int len;
      lvl = ~lvl;
      len = int'($urandom_range(1, 9));
      for (int j = 0; j < len; j++) step(lvl, 1'b0);
      if ($urandom_range(0, 39) == 0) step(lvl, 1'b1);
    end
    idle_out(12);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/btn_toggle_pulse.md
BTN_TOGGLE_PULSE -- requirements
Module: btn_toggle_pulse

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DB_CYCLES      1000000    stable cycles required to accept an edge; legal range >= 1
  REPEAT_DELAY   50000000   HELD cycles before the first auto-repeat pulse (AUTOREPEAT_EN only)
  REPEAT_PERIOD  10000000   cycles between later auto-repeat pulses (AUTOREPEAT_EN only)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk        input   1   single clock; all state updates on its rising edge
  rst        input   1   asynchronous, active-high reset
  btn_in     input   1   raw push-button level; asynchronous to clk and bouncing
  T          output  1   one-cycle toggle pulse that drives the downstream T flip-flop's T input
  btn_level  output  1   debounced button level
  busy       output  1   high whenever the FSM is not in IDLE

Function
REQ-003 btn_in SHALL pass through a 2-flop synchronizer; its output is called s.
REQ-004 The FSM SHALL have the states IDLE, DB_PRESS, HELD and DB_RELEASE.
REQ-005 IDLE: when s=1, go to DB_PRESS with cnt cleared to 0.
REQ-006 DB_PRESS, bounce case: when s=0, go to IDLE and clear cnt; no pulse is produced.
REQ-007 DB_PRESS, stable case: cnt increments each cycle that s=1; at cnt=DB_CYCLES-1 with s=1, go to HELD.
REQ-008 T SHALL be 1 for exactly the first cycle spent in HELD; it SHALL be registered, with no combinational path from btn_in.
REQ-009 HELD: when s=0, go to DB_RELEASE with cnt cleared to 0.
REQ-010 DB_RELEASE: when s=1, return to HELD with no new T pulse; at cnt=DB_CYCLES-1 with s=0, go to IDLE.
REQ-011 btn_level SHALL be 1 in HELD and DB_RELEASE, and 0 in IDLE and DB_PRESS.
REQ-012 Latency: with btn_in stable high, T SHALL assert on the (DB_CYCLES+3)th rising edge after the first edge that samples btn_in=1.
REQ-013 cnt width SHALL be $clog2(DB_CYCLES)+1; cnt never wraps because every state exit clears it.
REQ-014 Without auto-repeat, T SHALL never be high on two consecutive cycles and SHALL pulse exactly once per accepted press.
REQ-015 When s changes on the same cycle that cnt reaches its terminal count, the s value SHALL win: no transition to the next debounced state occurs.

Reset
REQ-016 rst=1 SHALL immediately force the following, independent of clk:
  - state = IDLE
  - cnt = 0
  - synchronizer flops = 0
  - repeat counter = 0
  - T = 0, btn_level = 0, busy = 0
REQ-017 A reset in any state SHALL abort that state with no pulse.
REQ-018 A button held through reset release SHALL be treated as a new press and SHALL get a full debounce before T.

Configuration
REQ-019 Macro AUTOREPEAT_EN defined: while in HELD, a repeat counter SHALL run.
  - T pulses REPEAT_DELAY cycles after the first HELD pulse, then every REPEAT_PERIOD cycles.
  - The repeat counter clears on leaving HELD.
  - A DB_RELEASE->HELD return restarts the repeat counter without a pulse.
REQ-020 Macro AUTOREPEAT_EN undefined: no repeat logic is synthesized; the REPEAT_* parameters are accepted and ignored, and REQ-014 holds.

Verification (DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3; edge 1 = first edge sampling btn_in=1)
REQ-021 rst=1 with btn_in=1 -> T=0, btn_level=0, busy=0 throughout reset; after release, T pulses on edge 7.
REQ-022 btn_in high for 20 cycles -> T=1 only in the cycle after edge 7; btn_level rises at edge 7; busy rises at edge 3.
REQ-023 btn_in high 3 cycles then low -> no T; busy returns to 0; btn_level stays 0.
REQ-024 In HELD, btn_in low 2 cycles then high -> no second T; btn_level stays 1 throughout.
REQ-025 rst pulse during DB_PRESS (edge 4) with btn_in kept high -> no T before reset; first T pulse 7 edges after reset release.
REQ-026 AUTOREPEAT_EN defined, btn_in held for 30 edges -> T pulses at edges 7, 15, 18, 21, 24, 27, 30; T=0 everywhere else.
